// File: rtl/alu_instr_encoder.sv
// Turns ALU op requests into RV32I OP / OP-IMM instruction words and buffers them in a small FIFO.
// Illegal requests still take a slot, but they come out as a NOP with the error flag set.
module alu_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic             in_is_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        op_ok, is_shift, illegal;
  logic [11:0] imm_fld;
  entry_t      enc;

  always_comb begin
    f3       = 3'b000;
    f7       = 7'b0000000;
    op_ok    = 1'b1;
    is_shift = 1'b0;
    case (in_alu_op)
      4'b0000: f3 = 3'b000;
      4'b0001: begin f3 = 3'b000; f7 = 7'b0100000; end
      4'b0100: begin f3 = 3'b001; is_shift = 1'b1; end
      4'b1101: f3 = 3'b010;
      4'b1100: f3 = 3'b011;
      4'b1011: f3 = 3'b100;
      4'b0110: begin f3 = 3'b101; is_shift = 1'b1; end
      4'b0111: begin f3 = 3'b101; f7 = 7'b0100000; is_shift = 1'b1; end
      4'b1010: f3 = 3'b110;
      4'b1001: f3 = 3'b111;
      default: op_ok = 1'b0;
    endcase
  end

  // Immediate-form SUB becomes ADDI with the negated immediate; -2048 has no positive counterpart.
  always_comb begin
    imm_fld = in_imm;
    illegal = !op_ok;
    if (in_is_imm) begin
      if (is_shift) begin
        imm_fld = {f7, in_imm[4:0]};
        if (in_imm[11:5] != 7'd0) illegal = 1'b1;
      end else if (in_alu_op == 4'b0001) begin
        imm_fld = 12'd0 - in_imm;
        if (in_imm == 12'h800) illegal = 1'b1;
      end
    end
  end

  always_comb begin
    enc.err   = illegal;
    enc.instr = in_is_imm ? {imm_fld, in_rs1, f3, in_rd, 7'h13}
                          : {f7, in_rs2, in_rs1, f3, in_rd, 7'h33};
    if (illegal) enc.instr = 32'h0000_0013;
  end

  logic push, pop;
  assign in_ready  = (occ < (AW+1)'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_instr = mem[rd_ptr].instr;
  assign out_err   = mem[rd_ptr].err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= enc;
          wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
          if (enc.err) err_count <= err_count + 1'b1;
          else         enc_count <= enc_count + 1'b1;
        end
        if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        if (push && !pop)      occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed checks of the ALU instruction encoder: encodings, illegal cases, FIFO order, flush and reset.
module tb_alu_instr_encoder;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_is_imm, flush;
  logic        out_valid, out_ready, out_err;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic [31:0] out_instr;
  logic [15:0] enc_count, err_count;
  int n_assert = 0;
  int n_fail   = 0;

  alu_instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_is_imm(in_is_imm), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic imm_f, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_valid = 1'b1; in_alu_op = op; in_is_imm = imm_f;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] op, input logic imm_f, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    set_req(op, imm_f, rd, rs1, rs2, imm);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_req(4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0); in_valid = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err",   {31'd0, out_err}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    step();

    send(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_err",   {31'd0, out_err}, 32'd0);

    send(4'b0111, 1'b1, 5'd5, 5'd6, 5'd0, 12'd7);
    chk("srai_instr", out_instr, 32'h40735293);
    chk("srai_err",   {31'd0, out_err}, 32'd0);
    send(4'b0100, 1'b1, 5'd5, 5'd6, 5'd0, 12'h020);
    chk("slli_big_instr", out_instr, 32'h00000013);
    chk("slli_big_err",   {31'd0, out_err}, 32'd1);

    send(4'b0001, 1'b1, 5'd1, 5'd1, 5'd0, 12'd5);
    chk("subi_instr", out_instr, 32'hFFB08093);
    chk("subi_err",   {31'd0, out_err}, 32'd0);
    send(4'b0001, 1'b1, 5'd1, 5'd1, 5'd0, 12'h800);
    chk("subi_min_instr", out_instr, 32'h00000013);
    chk("subi_min_err",   {31'd0, out_err}, 32'd1);

    send(4'b0010, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    chk("badop_instr", out_instr, 32'h00000013);
    chk("badop_err",   {31'd0, out_err}, 32'd1);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("enc_count_1", {16'd0, enc_count}, 32'd3);
    chk("err_count_1", {16'd0, err_count}, 32'd3);

    // Backpressure: fill two entries, hold a third, then release in order.
    out_ready = 1'b0;
    send(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    send(4'b0001, 1'b0, 5'd4, 5'd5, 5'd6, 12'd0);
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    set_req(4'b1010, 1'b0, 5'd7, 5'd8, 5'd9, 12'd0);
    step();
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_head",  out_instr, 32'h002081B3);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_instr, 32'h40628233);
    step();
    in_valid = 1'b0;
    chk("bp_head_c",  out_instr, 32'h009463B3);
    chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_empty",    {31'd0, out_valid}, 32'd0);
    chk("enc_count_2", {16'd0, enc_count}, 32'd6);
    chk("err_count_2", {16'd0, err_count}, 32'd3);

    // Flush with a simultaneous request drops everything, counters keep their values.
    out_ready = 1'b0;
    send(4'b1001, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    send(4'b1011, 1'b1, 5'd1, 5'd2, 5'd0, 12'hFFF);
    chk("pre_flush_enc", {16'd0, enc_count}, 32'd8);
    set_req(4'b0000, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_enc",   {16'd0, enc_count}, 32'd8);
    chk("flush_err",   {16'd0, err_count}, 32'd3);

    // Asynchronous reset mid-stream.
    send(4'b1100, 1'b0, 5'd2, 5'd3, 5'd4, 12'd0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_enc",   {16'd0, enc_count}, 32'd0);
    chk("mid_rst_err",   {16'd0, err_count}, 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
